// File: rtl/clk_div_gen_if.sv
// Control/status bundle for the programmable clock divider.
// The master side drives the run/ratio controls and the slave side returns the divided clock and status.
`timescale 1ns/1fs
interface clk_div_gen_if #(
    parameter int W = 8
);
    logic         en;
    logic         load;
    logic [W-1:0] div;
    logic         dclk;
    logic         tick;
    logic         running;
    logic [W-1:0] div_active;

    modport master (output en, load, div, input dclk, tick, running, div_active);
    modport slave  (input en, load, div, output dclk, tick, running, div_active);
endinterface

// File: rtl/clk_div_gen.sv
// Programmable integer clock divider: registered dclk with a one-cycle tick on each rising edge.
// Start, stop and ratio changes only take effect at period boundaries, so no runt pulses occur.
`timescale 1ns/1fs
module clk_div_gen #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         mclk,
    input  logic         rst_n,
    clk_div_gen_if.slave bus
);
    localparam logic [0:0]   IDLE_ST = 1'b0;
    localparam logic [0:0]   RUN_ST  = 1'b1;
    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_DIV = W'(2);

    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] v);
        if (v < MIN_DIV) begin
            return MIN_DIV;
        end else begin
            return v;
        end
    endfunction

    logic [0:0]   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pend_q, pend_d;
    logic [W-1:0] div_act_q, div_act_d;
    logic         dclk_q, dclk_d;
    logic         tick_q, tick_d;
    logic         running_q, running_d;

    logic [W-1:0] next_ratio_s;
    logic [W:0]   high_len_s;
    logic [W:0]   cnt_inc_s;
    logic         wrap_s;

    // Next-state logic: a load on the same edge as START/WRAP is applied immediately.
    always_comb begin
        next_ratio_s = bus.load ? clamp_div(bus.div) : pend_q;
        high_len_s   = ({1'b0, div_act_q} + {{W{1'b0}}, 1'b1}) >> 1;
        cnt_inc_s    = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
        wrap_s       = (cnt_q == (div_act_q - W'(1)));

        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = next_ratio_s;
        div_act_d = div_act_q;
        dclk_d    = dclk_q;
        tick_d    = 1'b0;

        case (state_q)
            IDLE_ST: begin
                if (bus.en) begin
                    state_d   = RUN_ST;
                    div_act_d = next_ratio_s;
                    cnt_d     = {W{1'b0}};
                    dclk_d    = 1'b1;
                    tick_d    = 1'b1;
                end else begin
                    cnt_d  = {W{1'b0}};
                    dclk_d = 1'b0;
                end
            end
            RUN_ST: begin
                if (wrap_s) begin
                    cnt_d = {W{1'b0}};
                    if (bus.en) begin
                        div_act_d = next_ratio_s;
                        dclk_d    = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d = IDLE_ST;
                        dclk_d  = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_inc_s[W-1:0];
                    dclk_d = (cnt_inc_s < high_len_s);
                end
            end
            default: begin
                state_d = IDLE_ST;
                cnt_d   = {W{1'b0}};
                dclk_d  = 1'b0;
            end
        endcase

        running_d = (state_d == RUN_ST);
    end

    // State and output registers; reset returns to idle with the default ratio.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE_ST;
            cnt_q     <= {W{1'b0}};
            pend_q    <= DEF_DIV;
            div_act_q <= DEF_DIV;
            dclk_q    <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            div_act_q <= div_act_d;
            dclk_q    <= dclk_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    assign bus.dclk       = dclk_q;
    assign bus.tick       = tick_q;
    assign bus.running    = running_q;
    assign bus.div_active = div_act_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen: default ratio, reload, graceful stop, clamp, async reset.
`timescale 1ns/1fs
module tb_clk_div_gen;
    logic mclk  = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    realtime rise_prev = 0.0;
    realtime rise_last = 0.0;

    clk_div_gen_if #(.W(8)) bus ();
    clk_div_gen #(.W(8), .DEFAULT_DIV(4)) dut (.mclk(mclk), .rst_n(rst_n), .bus(bus));

    always #1.953125 mclk = ~mclk;

    always @(posedge bus.dclk) begin
        rise_prev = rise_last;
        rise_last = $realtime;
    end

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic stop_gen();
        bit idle_seen;
        idle_seen = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (bus.running === 1'b0) begin
                idle_seen = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!idle_seen) begin
            errors++;
            $display("FAIL stop_timeout: running=%b required 0", bus.running);
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.load = 1'b0; bus.div = 8'd0;
        rst_n = 1'b0;
        #5;
        checks++; if (bus.dclk !== 1'b0) begin errors++; $display("FAIL reset_dclk: got %b expected 0", bus.dclk); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", bus.tick); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", bus.running); end
        checks++; if (bus.div_active !== 8'd4) begin errors++; $display("FAIL reset_div_active: got %0d expected 4", bus.div_active); end
        @(negedge mclk);
        rst_n = 1'b1;
        step();
        step();
        checks++; if (bus.dclk !== 1'b0 || bus.running !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: dclk=%b running=%b expected 0 0", bus.dclk, bus.running);
        end
    endtask

    task automatic test_default_ratio();
        logic exp_d, exp_t;
        bus.en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_d = ((i % 4) < 2);
            exp_t = ((i % 4) == 0);
            checks++; if (bus.dclk !== exp_d) begin errors++; $display("FAIL def_dclk[%0d]: got %b expected %b", i, bus.dclk, exp_d); end
            checks++; if (bus.tick !== exp_t) begin errors++; $display("FAIL def_tick[%0d]: got %b expected %b", i, bus.tick, exp_t); end
            checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL def_running[%0d]: got %b expected 1", i, bus.running); end
            checks++; if (bus.div_active !== 8'd4) begin errors++; $display("FAIL def_div_active[%0d]: got %0d expected 4", i, bus.div_active); end
        end
        checks++;
        if ((rise_last - rise_prev) > 15.626 || (rise_last - rise_prev) < 15.624) begin
            errors++; $display("FAIL def_period: got %f expected 15.625", rise_last - rise_prev);
        end
    endtask

    task automatic test_div5();
        logic exp_d, exp_t;
        stop_gen();
        bus.div = 8'd5; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++; if (bus.div_active !== 8'd4 || bus.running !== 1'b0) begin
            errors++; $display("FAIL div5_idle_load: div_active=%0d running=%b expected 4 0", bus.div_active, bus.running);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_d = ((i % 5) < 3);
            exp_t = ((i % 5) == 0);
            checks++; if (bus.dclk !== exp_d) begin errors++; $display("FAIL div5_dclk[%0d]: got %b expected %b", i, bus.dclk, exp_d); end
            checks++; if (bus.tick !== exp_t) begin errors++; $display("FAIL div5_tick[%0d]: got %b expected %b", i, bus.tick, exp_t); end
            checks++; if (bus.div_active !== 8'd5) begin errors++; $display("FAIL div5_div_active[%0d]: got %0d expected 5", i, bus.div_active); end
        end
    endtask

    task automatic test_ratio_change();
        logic exp_d, exp_t;
        logic [7:0] exp_n;
        int ph;
        stop_gen();
        bus.div = 8'd8; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 8) begin
                ph = i; exp_n = 8'd8; exp_d = (ph < 4);
            end else begin
                ph = (i - 8) % 3; exp_n = 8'd3; exp_d = (ph < 2);
            end
            exp_t = (ph == 0);
            checks++; if (bus.dclk !== exp_d) begin errors++; $display("FAIL chg_dclk[%0d]: got %b expected %b", i, bus.dclk, exp_d); end
            checks++; if (bus.tick !== exp_t) begin errors++; $display("FAIL chg_tick[%0d]: got %b expected %b", i, bus.tick, exp_t); end
            checks++; if (bus.div_active !== exp_n) begin errors++; $display("FAIL chg_div_active[%0d]: got %0d expected %0d", i, bus.div_active, exp_n); end
            if (i == 2) begin
                bus.load = 1'b1; bus.div = 8'd3;
            end else if (i == 8) begin
                bus.load = 1'b1; bus.div = 8'd6;
            end else if (i == 9) begin
                bus.load = 1'b1; bus.div = 8'd3;
            end else begin
                bus.load = 1'b0;
            end
        end
    endtask

    task automatic test_graceful_stop();
        logic exp_d, exp_t, exp_r;
        int ph;
        stop_gen();
        bus.div = 8'd4; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 4) begin
                exp_d = 1'b0; exp_t = 1'b0; exp_r = 1'b0;
            end else begin
                ph = (i < 4) ? i : ((i - 5) % 4);
                exp_d = (ph < 2); exp_t = (ph == 0); exp_r = 1'b1;
            end
            checks++; if (bus.dclk !== exp_d) begin errors++; $display("FAIL stop_dclk[%0d]: got %b expected %b", i, bus.dclk, exp_d); end
            checks++; if (bus.tick !== exp_t) begin errors++; $display("FAIL stop_tick[%0d]: got %b expected %b", i, bus.tick, exp_t); end
            checks++; if (bus.running !== exp_r) begin errors++; $display("FAIL stop_running[%0d]: got %b expected %b", i, bus.running, exp_r); end
            if (i == 1 || i == 6) begin
                bus.en = 1'b0;
            end else if (i == 4 || i == 7) begin
                bus.en = 1'b1;
            end
        end
    endtask

    task automatic test_clamp();
        logic exp_d;
        for (int v = 0; v < 2; v++) begin
            stop_gen();
            bus.div = 8'(v); bus.load = 1'b1;
            step();
            bus.load = 1'b0;
            bus.en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                exp_d = ((i % 2) == 0);
                checks++; if (bus.dclk !== exp_d) begin errors++; $display("FAIL clamp%0d_dclk[%0d]: got %b expected %b", v, i, bus.dclk, exp_d); end
                checks++; if (bus.tick !== exp_d) begin errors++; $display("FAIL clamp%0d_tick[%0d]: got %b expected %b", v, i, bus.tick, exp_d); end
                checks++; if (bus.div_active !== 8'd2) begin errors++; $display("FAIL clamp%0d_div_active[%0d]: got %0d expected 2", v, i, bus.div_active); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic exp_d, exp_t;
        stop_gen();
        bus.div = 8'd8; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.en = 1'b1;
        step();
        step();
        #0.5;
        rst_n = 1'b0;
        #0.1;
        checks++; if (bus.dclk !== 1'b0) begin errors++; $display("FAIL arst_dclk: got %b expected 0", bus.dclk); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL arst_running: got %b expected 0", bus.running); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL arst_tick: got %b expected 0", bus.tick); end
        checks++; if (bus.div_active !== 8'd4) begin errors++; $display("FAIL arst_div_active: got %0d expected 4", bus.div_active); end
        @(negedge mclk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_d = ((i % 4) < 2);
            exp_t = ((i % 4) == 0);
            checks++; if (bus.dclk !== exp_d) begin errors++; $display("FAIL arst_re_dclk[%0d]: got %b expected %b", i, bus.dclk, exp_d); end
            checks++; if (bus.tick !== exp_t) begin errors++; $display("FAIL arst_re_tick[%0d]: got %b expected %b", i, bus.tick, exp_t); end
            checks++; if (bus.div_active !== 8'd4) begin errors++; $display("FAIL arst_re_div_active[%0d]: got %0d expected 4", i, bus.div_active); end
        end
    endtask

    initial begin
        test_reset();
        test_default_ratio();
        test_div5();
        test_ratio_change();
        test_graceful_stop();
        test_clamp();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
